// File: rtl/acc_sched_ctrl.sv
// Job controller for the accumulator array: latches one layer config per start, gates
// per-column psum issue to the expected beat count, counts results and flags protocol errors.
module acc_sched_ctrl #(
  parameter int unsigned N_COL   = 128,
  parameter int unsigned OFMAP_W = 8,
  parameter int unsigned CH_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [OFMAP_W-1:0] ofmap_size_i,
  input  logic [CH_W-1:0]    ifmap_ch_i,
  output logic [OFMAP_W-1:0] ofmap_size_o,
  output logic [CH_W-1:0]    ifmap_ch_o,
  output logic [N_COL-1:0]   psum_en_o,
  input  logic [N_COL-1:0]   col_pvalid_i,
  input  logic [N_COL-1:0]   col_pready_i,
  input  logic [N_COL-1:0]   conv_valid_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  // One extra bit so (2^OFMAP_W)*(2^CH_W) fits at the all-ones config.
  localparam int unsigned BW = OFMAP_W + CH_W + 1;
  localparam int unsigned RW = OFMAP_W + 1;

  typedef enum logic [1:0] {StIdle, StCfg, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [OFMAP_W-1:0] ofmap_size_q, ofmap_size_d;
  logic [CH_W-1:0]    ifmap_ch_q, ifmap_ch_d;
  logic               err_q, err_d;
  logic [BW-1:0]      beat_cnt_q [N_COL];
  logic [BW-1:0]      beat_cnt_d [N_COL];
  logic [RW-1:0]      res_cnt_q  [N_COL];
  logic [RW-1:0]      res_cnt_d  [N_COL];

  logic [BW-1:0]    exp_beats;
  logic [RW-1:0]    exp_res;
  logic [N_COL-1:0] psum_en;
  logic             all_res;
  logic             err_set;

  assign exp_beats = (BW'(ofmap_size_q) + BW'(1)) * (BW'(ifmap_ch_q) + BW'(1));
  assign exp_res   = RW'(ofmap_size_q) + RW'(1);

  always_comb begin
    state_d      = state_q;
    ofmap_size_d = ofmap_size_q;
    ifmap_ch_d   = ifmap_ch_q;
    beat_cnt_d   = beat_cnt_q;
    res_cnt_d    = res_cnt_q;
    psum_en      = '0;
    all_res      = 1'b1;
    err_set      = 1'b0;

    for (int c = 0; c < N_COL; c++) begin
      psum_en[c] = (state_q == StRun) && (beat_cnt_q[c] != exp_beats);
      if (col_pvalid_i[c] && col_pready_i[c] && !psum_en[c]) err_set = 1'b1;
      if (conv_valid_i[c] && ((state_q != StRun) || (res_cnt_q[c] == exp_res))) begin
        err_set = 1'b1;
      end
      if (state_q == StRun) begin
        if (col_pvalid_i[c] && col_pready_i[c] && psum_en[c]) begin
          beat_cnt_d[c] = beat_cnt_q[c] + BW'(1);
        end
        if (conv_valid_i[c] && (res_cnt_q[c] < exp_res)) begin
          res_cnt_d[c] = res_cnt_q[c] + RW'(1);
        end
      end
    end

    // Completion looks at next-state counts so done follows the last result by one cycle.
    for (int c = 0; c < N_COL; c++) begin
      all_res = all_res & (res_cnt_d[c] == exp_res);
    end

    err_d = err_q | err_set;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          ofmap_size_d = ofmap_size_i;
          ifmap_ch_d   = ifmap_ch_i;
          err_d        = 1'b0;
          for (int c = 0; c < N_COL; c++) begin
            beat_cnt_d[c] = '0;
            res_cnt_d[c]  = '0;
          end
          state_d = StCfg;
        end
      end
      StCfg:   state_d = StRun;
      StRun:   if (all_res) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ofmap_size_q <= '0;
      ifmap_ch_q   <= '0;
      err_q        <= 1'b0;
      for (int c = 0; c < N_COL; c++) begin
        beat_cnt_q[c] <= '0;
        res_cnt_q[c]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      ofmap_size_q <= ofmap_size_d;
      ifmap_ch_q   <= ifmap_ch_d;
      err_q        <= err_d;
      beat_cnt_q   <= beat_cnt_d;
      res_cnt_q    <= res_cnt_d;
    end
  end

  assign ofmap_size_o = ofmap_size_q;
  assign ifmap_ch_o   = ifmap_ch_q;
  assign psum_en_o    = psum_en;
  assign busy_o       = (state_q == StCfg) || (state_q == StRun);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;

endmodule
